// File: rtl/flit_vc_rx_port_if.sv
// Drain-side handshake of the flit receive port: head flit, its VC and valid/ready.
interface flit_vc_rx_port_if #(
  parameter int FLIT_WIDTH = 16,
  parameter int VC_BITS    = 1
);
  logic [FLIT_WIDTH-1:0] deq_flit;
  logic [VC_BITS-1:0]    deq_vc;
  logic                  deq_valid;
  logic                  deq_ready;

  modport master (output deq_flit, output deq_vc, output deq_valid, input deq_ready);
  modport slave  (input deq_flit, input deq_vc, input deq_valid, output deq_ready);
endinterface

// File: rtl/flit_vc_rx_port.sv
// Credit-based flit receiver: per-VC FIFOs drained round-robin through one
// valid/ready port, returning one registered credit per dequeued flit.
module flit_vc_rx_port #(
  parameter int FLIT_WIDTH = 16,
  parameter int NUM_VCS    = 2,
  parameter int VC_BITS    = 1,
  parameter int VC_LSB     = 0,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [FLIT_WIDTH-1:0] putFlit_flit_in,
  input  logic                  EN_putFlit,
  output logic [VC_BITS:0]      getCredits,
  input  logic                  EN_getCredits,
  flit_vc_rx_port_if.master     deq,
  output logic                  overflow_err
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [FLIT_WIDTH-1:0] mem [NUM_VCS][DEPTH];
  logic [PTR_W-1:0]      head [NUM_VCS];
  logic [PTR_W-1:0]      tail [NUM_VCS];
  logic [PTR_W:0]        cnt  [NUM_VCS];
  logic [VC_BITS-1:0]    rr_ptr;

  logic                  arrive;
  logic [VC_BITS-1:0]    vc_in;
  logic                  vc_ok;
  logic                  drop;
  logic                  fire;
  logic [NUM_VCS-1:0]    enq_v;
  logic [NUM_VCS-1:0]    deq_v;
  logic [NUM_VCS-1:0]    full_v;
  logic [VC_BITS-1:0]    sel;
  logic                  found;
  int                    idx;

  logic                  credit_vld_p1;
  logic [VC_BITS-1:0]    credit_vc_p1;

  // The poll strobe carries no information for this side of the link.
  logic                  unused_poll;
  assign unused_poll = EN_getCredits;

  // Stage p0: combinational round-robin pick and enqueue/dequeue decode
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_VCS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_VCS;
      if (!found && cnt[idx] != '0) begin
        found = 1'b1;
        sel   = VC_BITS'(idx);
      end
    end
  end

  assign deq.deq_valid = found;
  assign deq.deq_vc    = found ? sel : '0;
  assign deq.deq_flit  = found ? mem[sel][head[sel]] : '0;
  assign fire          = found & deq.deq_ready;

  assign arrive = EN_putFlit & putFlit_flit_in[FLIT_WIDTH-1];
  assign vc_in  = putFlit_flit_in[VC_LSB +: VC_BITS];
  assign vc_ok  = (int'(vc_in) < NUM_VCS);

  always_comb begin
    drop = arrive & ~vc_ok;
    for (int v = 0; v < NUM_VCS; v++) begin
      full_v[v] = (cnt[v] == (PTR_W+1)'(DEPTH));
      deq_v[v]  = fire && (sel == VC_BITS'(v));
      // A full VC still accepts when its head leaves on the same edge.
      enq_v[v]  = arrive && vc_ok && (vc_in == VC_BITS'(v)) && (!full_v[v] || deq_v[v]);
      if (arrive && vc_ok && (vc_in == VC_BITS'(v)) && full_v[v] && !deq_v[v])
        drop = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    for (int v = 0; v < NUM_VCS; v++)
      if (enq_v[v]) mem[v][tail[v]] <= putFlit_flit_in;
  end

  // Stage p1: pointer/count update and registered credit return
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        head[v] <= '0;
        tail[v] <= '0;
        cnt[v]  <= '0;
      end
      rr_ptr        <= '0;
      credit_vld_p1 <= 1'b0;
      credit_vc_p1  <= '0;
      overflow_err  <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (enq_v[v]) tail[v] <= tail[v] + PTR_W'(1);
        if (deq_v[v]) head[v] <= head[v] + PTR_W'(1);
        case ({enq_v[v], deq_v[v]})
          2'b10:   cnt[v] <= cnt[v] + (PTR_W+1)'(1);
          2'b01:   cnt[v] <= cnt[v] - (PTR_W+1)'(1);
          default: cnt[v] <= cnt[v];
        endcase
      end
      if (fire) rr_ptr <= VC_BITS'((int'(sel) + 1) % NUM_VCS);
      credit_vld_p1 <= fire;
      credit_vc_p1  <= fire ? sel : '0;
      if (drop) overflow_err <= 1'b1;
    end
  end

  assign getCredits = {credit_vld_p1, credit_vc_p1};
endmodule

// File: tb/tb_flit_vc_rx_port.sv
// Directed bench for flit_vc_rx_port: enqueue, overflow, round-robin drain, credits, reset.
module tb_flit_vc_rx_port;
  localparam int FW = 16;
  localparam int VB = 1;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic [FW-1:0] flit_in;
  logic          en_put;
  logic [VB:0]   credits;
  logic          en_get;
  logic          ovf;

  int total;
  int bad;

  flit_vc_rx_port_if #(.FLIT_WIDTH(FW), .VC_BITS(VB)) dq ();

  flit_vc_rx_port #(
    .FLIT_WIDTH(FW), .NUM_VCS(2), .VC_BITS(VB), .VC_LSB(0), .DEPTH(DEPTH)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .putFlit_flit_in(flit_in), .EN_putFlit(en_put),
    .getCredits(credits), .EN_getCredits(en_get), .deq(dq.master), .overflow_err(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkf(input logic [7:0] p, input logic vc);
    return {1'b1, 6'd0, p, vc};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic put(input logic [7:0] p, input logic vc);
    en_put  = 1'b1;
    flit_in = mkf(p, vc);
    tick();
    en_put  = 1'b0;
    flit_in = '0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    flit_in = '0;
    en_put = 1'b0;
    en_get = 1'b1;
    dq.deq_ready = 1'b0;
    tick();
    do_reset();

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("idle_valid", 32'(dq.deq_valid), 0);
      chk("idle_credit", 32'(credits), 0);
      chk("idle_ovf", 32'(ovf), 0);
      tick();
    end

    // Single flit on VC1
    dq.deq_ready = 1'b1;
    put(8'hA5, 1'b1);
    chk("single_valid", 32'(dq.deq_valid), 1);
    chk("single_vc", 32'(dq.deq_vc), 1);
    chk("single_flit", 32'(dq.deq_flit), 32'(16'h814B));
    chk("single_credit0", 32'(credits), 0);
    tick();
    chk("single_credit", 32'(credits), 32'(2'b11));
    chk("single_empty", 32'(dq.deq_valid), 0);
    tick();
    chk("single_credit_off", 32'(credits), 0);

    // Fill VC0, then overflow
    dq.deq_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) put(8'(i), 1'b0);
    chk("fill_ovf", 32'(ovf), 0);
    chk("fill_valid", 32'(dq.deq_valid), 1);
    put(8'h55, 1'b0);
    chk("over_ovf", 32'(ovf), 1);
    dq.deq_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", 32'(dq.deq_valid), 1);
      chk("drain_flit", 32'(dq.deq_flit), 32'(mkf(8'(i), 1'b0)));
      tick();
      chk("drain_credit", 32'(credits), 32'(2'b10));
    end
    chk("drain_empty", 32'(dq.deq_valid), 0);
    chk("drain_ovf_sticky", 32'(ovf), 1);
    dq.deq_ready = 1'b0;
    tick();

    // Full VC0 with same-cycle dequeue accepts the new flit
    do_reset();
    for (int i = 0; i < DEPTH; i++) put(8'h10 + 8'(i), 1'b0);
    dq.deq_ready = 1'b1;
    chk("fullfire_head", 32'(dq.deq_flit), 32'(mkf(8'h10, 1'b0)));
    put(8'h10 + 8'(DEPTH), 1'b0);
    chk("fullfire_ovf", 32'(ovf), 0);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("fullfire_valid", 32'(dq.deq_valid), 1);
      chk("fullfire_flit", 32'(dq.deq_flit), 32'(mkf(8'h10 + 8'(i), 1'b0)));
      tick();
    end
    chk("fullfire_empty", 32'(dq.deq_valid), 0);
    chk("fullfire_ovf_end", 32'(ovf), 0);
    dq.deq_ready = 1'b0;

    // Round-robin across both VCs
    do_reset();
    for (int i = 0; i < 3; i++) put(8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) put(8'h30 + 8'(i), 1'b1);
    dq.deq_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_valid", 32'(dq.deq_valid), 1);
      chk("rr_vc", 32'(dq.deq_vc), 32'(k % 2));
      chk("rr_flit", 32'(dq.deq_flit),
          32'(mkf(((k % 2) == 0 ? 8'h20 : 8'h30) + 8'(k / 2), 1'((k % 2)))));
      if (k > 0) chk("rr_credit", 32'(credits), 32'({1'b1, 1'((k - 1) % 2)}));
      else       chk("rr_credit_first", 32'(credits), 0);
      tick();
    end
    chk("rr_credit_last", 32'(credits), 32'(2'b11));
    chk("rr_empty", 32'(dq.deq_valid), 0);
    tick();
    chk("rr_credit_off", 32'(credits), 0);
    dq.deq_ready = 1'b0;

    // Reset discards buffered flits
    put(8'h40, 1'b1);
    put(8'h41, 1'b1);
    chk("prerst_valid", 32'(dq.deq_valid), 1);
    rst_n = 1'b0;
    dq.deq_ready = 1'b1;
    tick();
    chk("rst_valid", 32'(dq.deq_valid), 0);
    chk("rst_credit", 32'(credits), 0);
    rst_n = 1'b1;
    tick();
    chk("postrst_credit", 32'(credits), 0);
    put(8'h77, 1'b0);
    chk("postrst_valid", 32'(dq.deq_valid), 1);
    chk("postrst_vc", 32'(dq.deq_vc), 0);
    chk("postrst_flit", 32'(dq.deq_flit), 32'(mkf(8'h77, 1'b0)));
    tick();
    chk("postrst_credit1", 32'(credits), 32'(2'b10));
    chk("postrst_empty", 32'(dq.deq_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
